// File: rtl/awgn_sched.sv
// awgn_sched: Box-Muller AWGN sequencer. It loads and steps the URNG, tracks tokens through the fixed-latency datapath and buffers the x0/x1 pairs.
// Defining AWGN_SCHED_CNT_EN adds the 32-bit output-transfer counter port sample_count.
module awgn_sched #(
  parameter int DATA_W     = 16,
  parameter int PIPE_LAT   = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              seed_load,
  output logic              urng_load,
  output logic              urng_step,
  input  logic [DATA_W-1:0] dp_x0,
  input  logic [DATA_W-1:0] dp_x1,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
`ifdef AWGN_SCHED_CNT_EN
  output logic [31:0]       sample_count,
`endif
  output logic              busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int IW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, SEED, RUN} state_e;

  state_e              state_q, state_d;
  logic [PIPE_LAT-1:0] tok_q, tok_d;
  logic [IW-1:0]       inflight_q, inflight_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic tok_exit;
  logic xfer;
  logic credit_ok;

  // Credit reserves buffer room for every token already in flight, so no pair is ever dropped.
  assign credit_ok    = (int'(count_q) + 2 * int'(inflight_q) + 2) <= FIFO_DEPTH;
  assign tok_exit     = tok_q[PIPE_LAT-1];
  assign sample_valid = (count_q != '0);
  assign xfer         = sample_valid && sample_ready;
  assign sample_out   = sample_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (seed_load)   state_d = SEED;
        else if (enable) state_d = RUN;
      end
      SEED:    state_d = enable ? RUN : IDLE;
      RUN: begin
        if (seed_load)                           state_d = SEED;
        else if (!enable && inflight_q == '0)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    urng_load = (state_q == SEED);
    urng_step = (state_q == RUN) && enable && !seed_load && credit_ok;
    busy      = (state_q == SEED) || (inflight_q != '0);
  end

  always_comb begin
    tok_d      = (tok_q << 1) | PIPE_LAT'(urng_step);
    inflight_d = inflight_q + IW'(urng_step) - IW'(tok_exit);
    wr_ptr_d   = tok_exit ? wr_ptr_q + PW'(2) : wr_ptr_q;
    rd_ptr_d   = xfer ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + (tok_exit ? CW'(2) : CW'(0)) - CW'(xfer);
    // SEED discards in-flight tokens and flushes the buffer.
    if (state_q == SEED) begin
      tok_d      = '0;
      inflight_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tok_q      <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      tok_q      <= tok_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // wr_ptr is always even, so the pair lands in adjacent slots.
  always_ff @(posedge clk) begin
    if (!reset && tok_exit && state_q != SEED) begin
      mem_q[wr_ptr_q]          <= dp_x0;
      mem_q[wr_ptr_q + PW'(1)] <= dp_x1;
    end
  end

`ifdef AWGN_SCHED_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 32'(xfer);
    if (state_q == SEED) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_count = cnt_q;
`endif

endmodule

// File: doc/awgn_sched.md
Name: awgn_sched

Overview:
- Sequencing controller for the Box-Muller AWGN datapath (URNG -> log/sqrt/cos -> x0/x1 pair).
- Loads and steps the URNG seed generator, tracks samples in flight through the fixed-latency datapath, and buffers each x0/x1 pair.
- Buffered pairs are serialised to a single consumer through a valid/ready stream.
- Back-pressure from the consumer throttles URNG stepping, so no sample is ever dropped.

Parameters:
- DATA_W, 16, width of x0/x1 and of the output sample.
- PIPE_LAT, 8, cycles from urng_step to matching dp_x0/dp_x1 valid at the datapath output (>=1).
- FIFO_DEPTH, 32, output buffer depth in samples (power of 2, even, >=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; permits issuing new URNG steps.
- seed_load  in  1  one-cycle pulse; reseed request.
- urng_load  out  1  one-cycle pulse to the URNG: load seeds.
- urng_step  out  1  advance the URNG one step; one datapath sample pair enters.
- dp_x0  in  DATA_W  datapath output x0.
- dp_x1  in  DATA_W  datapath output x1.
- sample_out  out  DATA_W  head-of-buffer sample.
- sample_valid  out  1  sample_out valid.
- sample_ready  in  1  consumer accepts.
- busy  out  1  high in SEED state or while tokens are in flight.

Behaviour:
- Reset (sync, active-high) clears the following on that clock edge: state=IDLE, urng_load=0, urng_step=0, token shift register, inflight, FIFO pointers, count, sample_valid=0, sample_out=0, busy=0.
- FSM states: IDLE, SEED, RUN.
  - IDLE: enable=1 -> RUN; seed_load=1 -> SEED (seed_load has priority).
  - SEED: lasts exactly 1 cycle with urng_load=1. Clears tokens, inflight, FIFO pointers and count. Next state is RUN if enable=1, else IDLE.
  - RUN: seed_load=1 -> SEED. When enable=0 and inflight=0, go to IDLE; the FIFO keeps draining in IDLE.
- Step issue: urng_step=1 in a cycle only when all of the following hold:
  - state=RUN, enable=1, seed_load=0;
  - count + 2*inflight + 2 <= FIFO_DEPTH. A read in the same cycle is ignored (conservative).
- Token tracking: a PIPE_LAT-bit shift register. Bit 0 is set when urng_step=1, and the register shifts every cycle.
  - inflight = popcount, kept as a counter: +1 on step, -1 on token exit.
  - On token exit, dp_x0 is written at wr_ptr and dp_x1 at wr_ptr+1 (two writes in one cycle), then wr_ptr += 2.
- Latency: urng_step at edge t -> write at edge t+PIPE_LAT -> sample_valid=1 from cycle t+PIPE_LAT+1. Output order is x0 then x1 of each step, in step order.
- Read side: sample_valid = (count != 0); sample_out = mem[rd_ptr]. Transfer on sample_valid & sample_ready, then rd_ptr += 1.
  - Holding rule: sample_out is stable while valid & !ready.
- Count update per cycle: +2 on token exit, -1 on transfer, both in one cycle = +1. Overflow cannot occur by the credit rule; empty means valid=0 and reads are ignored. Pointers wrap modulo FIFO_DEPTH.
- seed_load during RUN (reset mid-operation): all in-flight tokens are discarded, and datapath outputs for them are never written. The FIFO is flushed, so buffered samples are lost and sample_valid=0 the cycle after SEED.
- enable falling: no new steps; in-flight tokens still complete and are written. busy falls the cycle after the last token exits.
- Sustained rate with sample_ready=1: 1 sample/cycle, urng_step at 50% duty, requires FIFO_DEPTH >= 2*PIPE_LAT+2.

Optional Feature:
- Macro: AWGN_SCHED_CNT_EN.
- Defined: adds output sample_count [31:0]. Cleared by reset and by SEED; +1 per output transfer; wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, enable=1, sample_ready=1, dp_x0=step index, dp_x1=~step index -> first urng_step 1 cycle after RUN entry; first sample_valid exactly 9 cycles after the first step; order 0, 0xFFFF, 1, 0xFFFE, ...
- sample_ready=0 throughout, enable=1 -> exactly 16 urng_step pulses, then urng_step stays 0; count=32; raising ready drains 32 samples in order with no loss.
- Steady state ready=1 over 200 cycles -> sample_valid=1 every cycle; urng_step asserted in exactly 100 cycles; no gaps.
- seed_load pulse with inflight=5 and count=10 -> next cycle urng_load=1; then sample_valid=0 and count=0; the 5 stale tokens produce no writes; the first new sample appears 9 cycles after the next step.
- enable dropped with inflight=8 -> no further steps; 16 samples appended; busy=0 one cycle after the last exit; FSM returns to IDLE.
- With AWGN_SCHED_CNT_EN: counter preloaded near wrap via 0xFFFFFFFE transfers (forced) -> two transfers give 0x00000000; SEED clears it to 0.
